alu_multibyte_seq: RTL and testbench

Sequencer that runs multi-byte (NBYTES x 8-bit) arithmetic and logic operations on the shared 8-bit combinational ALU, one byte per clock.
- Chains the ALU carry/borrow least-significant byte first.
- Accumulates the result and composite zero flag, and reports completion with a start/busy/done handshake.
- Sits between the instruction control path and the ALU: drives all ALU inputs and consumes its outputs.

---
 rtl/alu_multibyte_seq.sv | 149 ++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// Multi-byte sequencer for the shared 8-bit ALU.
// Processes one byte per clock, least-significant byte first, and chains carry/borrow between bytes.
module alu_multibyte_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  carry_in,
  input  logic [8*NBYTES-1:0]   opnd_a,
  input  logic [8*NBYTES-1:0]   opnd_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  zero_out,
  output logic [7:0]            alu_in1,
  output logic [7:0]            alu_in2,
  output logic                  alu_cin,
  output logic [2:0]            alu_opcode,
  input  logic [7:0]            alu_res,
  input  logic                  alu_cout,
  input  logic                  alu_zero
);

  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;
  localparam logic [2:0] SUB_FN  = 3'd2;
  localparam logic [2:0] SUBC_FN = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_d;
  logic [IDXW-1:0]          idx;
  logic [2:0]               op_q;
  logic                     cin_q;
  logic [NBYTES-1:0][7:0]   a_q, b_q, acc, acc_d;
  logic                     carry_q;
  logic                     zacc;
  logic                     last;
  logic                     is_logic;

  assign is_logic = op_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus ALU drive; the ALU sits idle (reset values) outside RUN.
  always_comb begin
    state_d    = state;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_cin    = 1'b0;
    alu_opcode = ADD_FN;
    acc_d      = acc;
    last       = (idx == IDXW'(NBYTES - 1));
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        alu_in1    = a_q[idx];
        alu_in2    = b_q[idx];
        acc_d[idx] = alu_res;
        unique case (op_q)
          ADD_FN, SUB_FN: begin
            if (idx == '0) begin
              alu_opcode = op_q;
              alu_cin    = 1'b0;
            end else begin
              alu_opcode = (op_q == ADD_FN) ? ADDC_FN : SUBC_FN;
              alu_cin    = carry_q;
            end
          end
          ADDC_FN, SUBC_FN: begin
            alu_opcode = op_q;
            alu_cin    = (idx == '0) ? cin_q : carry_q;
          end
          default: begin
            alu_opcode = op_q;
            alu_cin    = 1'b0;
          end
        endcase
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, byte accumulation and final flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      op_q      <= ADD_FN;
      cin_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      zacc      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            cin_q   <= carry_in;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            acc     <= '0;
            zacc    <= 1'b1;
            carry_q <= 1'b0;
            idx     <= '0;
          end
        end
        RUN: begin
          acc     <= acc_d;
          carry_q <= alu_cout;
          zacc    <= zacc & alu_zero;
          idx     <= IDXW'(idx + 1'b1);
          if (last) begin
            result    <= acc_d;
            // The ALU leaves cout undefined on logic functions.
            carry_out <= is_logic ? 1'b0 : alu_cout;
            zero_out  <= zacc & alu_zero;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq: behavioural 8-bit ALU in the loop, whole-word reference model.
module tb_alu_multibyte_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     op = 3'd0;
  logic           carry_in = 1'b0;
  logic [W-1:0]   opnd_a = '0;
  logic [W-1:0]   opnd_b = '0;
  logic           busy, done, carry_out, zero_out;
  logic [W-1:0]   result;
  logic [7:0]     alu_in1, alu_in2, alu_res;
  logic           alu_cin, alu_cout, alu_zero;
  logic [2:0]     alu_opcode;

  int checks = 0;
  int errors = 0;

  alu_multibyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .carry_in(carry_in),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero_out(zero_out), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_cin(alu_cin), .alu_opcode(alu_opcode), .alu_res(alu_res),
    .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Shared 8-bit ALU; cout is junk (1) on logic functions.
  logic [8:0] t9;
  always_comb begin
    t9 = '0;
    case (alu_opcode)
      3'd0: t9 = {1'b0, alu_in1} + {1'b0, alu_in2};
      3'd1: t9 = {1'b0, alu_in1} + {1'b0, alu_in2} + 9'(alu_cin);
      3'd2: t9 = {1'b0, alu_in1} - {1'b0, alu_in2};
      3'd3: t9 = {1'b0, alu_in1} - {1'b0, alu_in2} - 9'(alu_cin);
      3'd4: t9 = {1'b1, alu_in1 & alu_in2};
      3'd5: t9 = {1'b1, alu_in1 | alu_in2};
      3'd6: t9 = {1'b1, alu_in1 ^ alu_in2};
      default: t9 = {1'b1, alu_in1 & ~alu_in2};
    endcase
  end
  assign alu_res  = t9[7:0];
  assign alu_cout = t9[8];
  assign alu_zero = (t9[7:0] == 8'h00);

  // Whole-word reference: carry = unsigned overflow, borrow = a < b + cin.
  task automatic ref_model(input logic [2:0] f, input logic ci, input logic [W-1:0] a, b,
                           output logic [W-1:0] r, output logic c, output logic z);
    logic [W:0] t;
    t = '0;
    case (f)
      3'd0: t = {1'b0, a} + {1'b0, b};
      3'd1: t = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      3'd2: t = {1'b0, a} - {1'b0, b};
      3'd3: t = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      3'd4: t = {1'b0, a & b};
      3'd5: t = {1'b0, a | b};
      3'd6: t = {1'b0, a ^ b};
      default: t = {1'b0, a & ~b};
    endcase
    r = t[W-1:0];
    c = t[W];
    z = (r == '0);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < int'(NB); i++) w[8*i +: 8] = 8'($urandom);
    return w;
  endfunction

  // Issue one operation; optionally scramble inputs and pulse start while running.
  task automatic run_op(input logic [2:0] f, input logic ci, input logic [W-1:0] a, b,
                        input bit scramble, output int lat, output int bcnt, output int dones);
    @(negedge clk);
    start = 1'b1; op = f; carry_in = ci; opnd_a = a; opnd_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; dones = 0;
    for (int k = 1; k <= int'(NB) + 4; k++) begin
      if (scramble && k < int'(NB)) begin
        start = 1'($urandom); op = 3'($urandom); carry_in = 1'($urandom);
        opnd_a = rand_word(); opnd_b = rand_word();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dones++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_hs busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== '0 || carry_out !== 1'b0 || zero_out !== 1'b0) begin errors++; $display("FAIL reset_out result=%h c=%b z=%b want 0 0 0", result, carry_out, zero_out); end
    checks++; if (alu_in1 !== 8'h00 || alu_in2 !== 8'h00 || alu_cin !== 1'b0 || alu_opcode !== 3'd0) begin errors++; $display("FAIL reset_alu in1=%h in2=%h cin=%b opc=%0d want 0 0 0 0", alu_in1, alu_in2, alu_cin, alu_opcode); end
  endtask

  task automatic test_directed();
    int lat, bcnt, dones;
    run_op(3'd0, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'h0100_0000 || carry_out !== 1'b0 || zero_out !== 1'b0) begin errors++; $display("FAIL add_ripple got %h c=%b z=%b want 01000000 0 0", result, carry_out, zero_out); end
    checks++; if (lat != int'(NB) + 1 || bcnt != int'(NB) + 1 || dones != 1) begin errors++; $display("FAIL latency lat=%0d busy=%0d dones=%0d want %0d %0d 1", lat, bcnt, dones, NB + 1, NB + 1); end
    run_op(3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'h0 || carry_out !== 1'b1 || zero_out !== 1'b1) begin errors++; $display("FAIL add_wrap got %h c=%b z=%b want 00000000 1 1", result, carry_out, zero_out); end
    run_op(3'd6, 1'b0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'h0 || carry_out !== 1'b0 || zero_out !== 1'b1) begin errors++; $display("FAIL xor_self got %h c=%b z=%b want 00000000 0 1", result, carry_out, zero_out); end
    run_op(3'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'h0 || carry_out !== 1'b0 || zero_out !== 1'b1) begin errors++; $display("FAIL mask_all got %h c=%b z=%b want 00000000 0 1", result, carry_out, zero_out); end
    run_op(3'd2, 1'b0, 32'h0, 32'h0000_0001, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'hFFFF_FFFF || carry_out !== 1'b1 || zero_out !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h c=%b z=%b want ffffffff 1 0", result, carry_out, zero_out); end
    run_op(3'd3, 1'b1, 32'h0000_0100, 32'h0, 1'b0, lat, bcnt, dones);
    checks++; if (result !== 32'h0000_00FF || carry_out !== 1'b0 || zero_out !== 1'b0) begin errors++; $display("FAIL subc_cin got %h c=%b z=%b want 000000ff 0 0", result, carry_out, zero_out); end
  endtask

  task automatic test_ignore_start();
    int lat, bcnt, dones;
    logic [W-1:0] er; logic ec, ez;
    ref_model(3'd0, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, er, ec, ez);
    @(negedge clk);
    start = 1'b1; op = 3'd0; carry_in = 1'b0; opnd_a = 32'h1234_5678; opnd_b = 32'h0FED_CBA9;
    @(posedge clk); #1;
    op = 3'd5; opnd_a = 32'hDEAD_BEEF; opnd_b = 32'hCAFE_F00D;
    dones = 0;
    for (int k = 1; k <= int'(NB) + 4; k++) begin
      start = (k == 2);
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    checks++; if (result !== er || carry_out !== ec || zero_out !== ez) begin errors++; $display("FAIL start_during_run got %h c=%b z=%b want %h %b %b", result, carry_out, zero_out, er, ec, ez); end
    checks++; if (dones != 1) begin errors++; $display("FAIL single_done got %0d want 1", dones); end
  endtask

  task automatic test_random();
    int lat, bcnt, dones;
    logic [2:0] f; logic ci; logic [W-1:0] a, b, er; logic ec, ez;
    for (int n = 0; n < 60; n++) begin
      f = 3'($urandom); ci = 1'($urandom); a = rand_word();
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = ~a;
        default: b = rand_word();
      endcase
      ref_model(f, ci, a, b, er, ec, ez);
      run_op(f, ci, a, b, 1'($urandom), lat, bcnt, dones);
      checks++; if (result !== er || carry_out !== ec || zero_out !== ez) begin errors++; $display("FAIL random op=%0d cin=%b a=%h b=%h got %h c=%b z=%b want %h %b %b", f, ci, a, b, result, carry_out, zero_out, er, ec, ez); end
      checks++; if (lat != int'(NB) + 1 || dones != 1) begin errors++; $display("FAIL random_timing lat=%0d dones=%0d want %0d 1", lat, dones, NB + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [W-1:0] er; logic ec, ez;
    @(negedge clk);
    start = 1'b1; op = 3'd1; carry_in = 1'b1; opnd_a = 32'h8000_00FF; opnd_b = 32'h8000_0000;
    gap = 0;
    while (!done && gap < 40) begin @(negedge clk); gap++; end
    ref_model(3'd1, 1'b1, 32'h8000_00FF, 32'h8000_0000, er, ec, ez);
    checks++; if (!done || result !== er || carry_out !== ec) begin errors++; $display("FAIL b2b_first done=%b got %h c=%b want %h %b", done, result, carry_out, er, ec); end
    op = 3'd2; carry_in = 1'b0; opnd_a = 32'h0000_0005; opnd_b = 32'h0000_0005;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!done && gap < 40);
    start = 1'b0;
    checks++; if (gap != int'(NB) + 2 || result !== 32'h0 || carry_out !== 1'b0 || zero_out !== 1'b1) begin errors++; $display("FAIL b2b_second gap=%0d got %h c=%b z=%b want %0d 00000000 0 1", gap, result, carry_out, zero_out, NB + 2); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int lat, bcnt, dones;
    logic [W-1:0] er; logic ec, ez;
    @(negedge clk);
    start = 1'b1; op = 3'd0; carry_in = 1'b0; opnd_a = 32'h1122_3344; opnd_b = 32'h0101_0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (alu_in1 !== 8'h22 || alu_in2 !== 8'h01 || alu_opcode !== 3'd1) begin errors++; $display("FAIL byte2_drive in1=%h in2=%h opc=%0d want 22 01 1", alu_in1, alu_in2, alu_opcode); end
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0 || zero_out !== 1'b0) begin errors++; $display("FAIL midop_reset busy=%b done=%b result=%h c=%b z=%b want all 0", busy, done, result, carry_out, zero_out); end
    checks++; if (alu_in1 !== 8'h00 || alu_opcode !== 3'd0 || alu_cin !== 1'b0) begin errors++; $display("FAIL midop_reset_alu in1=%h opc=%0d cin=%b want 0 0 0", alu_in1, alu_opcode, alu_cin); end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (NB + 2) begin @(negedge clk); if (done || busy) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL no_done_after_abort activity=%0d want 0", dones); end
    ref_model(3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, er, ec, ez);
    run_op(3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, bcnt, dones);
    checks++; if (result !== er || carry_out !== ec || zero_out !== ez || dones != 1) begin errors++; $display("FAIL after_abort got %h c=%b z=%b dones=%0d want %h %b %b 1", result, carry_out, zero_out, dones, er, ec, ez); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
